// File: rtl/scr_tx_arbiter.sv
// rtl/scr_tx_arbiter.sv - round-robin 2-phase req/ack arbiter feeding one serializer.
// Optional per-link packet counters are built only when SCR_ARB_STATS_EN is defined.
module scr_tx_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int PKT_W = 32,
    parameter  int CNT_W = 16,
    localparam int SRC_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       in_req,
    output logic [N_REQ-1:0]       in_ack,
    input  logic [N_REQ*PKT_W-1:0] in_data,
    output logic                   out_req,
    input  logic                   out_ack,
    output logic [PKT_W-1:0]       out_data,
    output logic [SRC_W-1:0]       out_src,
    output logic                   busy,
    output logic [N_REQ*CNT_W-1:0] pkt_cnt
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state;
    logic [SRC_W-1:0] rr_ptr;
    logic [N_REQ-1:0] pend;
    logic             grant_valid;
    logic [SRC_W-1:0] grant_idx;
    logic             grant_fire;

    assign pend       = in_req ^ in_ack;
    assign grant_fire = (state == IDLE) && grant_valid;

    // Scan downward so the last hit is the first pending link at or after rr_ptr.
    always_comb begin
        int               idx;
        logic [SRC_W-1:0] idx_t;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        idx_t       = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_t = SRC_W'(idx);
            if (pend[idx_t]) begin
                grant_valid = 1'b1;
                grant_idx   = idx_t;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            in_ack   <= '0;
            out_req  <= 1'b0;
            out_data <= '0;
            out_src  <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        out_data <= in_data[grant_idx*PKT_W +: PKT_W];
                        out_src  <= grant_idx;
                        in_ack   <= in_ack ^ (N_REQ'(1) << grant_idx);
                        out_req  <= ~out_req;
                        busy     <= 1'b1;
                        rr_ptr   <= (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (out_ack == out_req) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCR_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_REQ];

    // Saturating: a counter stuck at all-ones stays there until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (grant_fire && (cnt_q[grant_idx] != {CNT_W{1'b1}})) begin
            cnt_q[grant_idx] <= cnt_q[grant_idx] + 1'b1;
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
        assign pkt_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
    end
`else
    logic unused_fire;
    assign unused_fire = grant_fire;
    assign pkt_cnt     = '0;
`endif

endmodule
